fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 'h8000_0000, PC loaded by reset.
REQ-002 SHALL have clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have F_stall_i  input  1  hazard unit hold; buffered instruction not consumed.
REQ-005 SHALL have redirect_i  input  1  mispredict/jump correction from execute.
REQ-006 SHALL have redirect_pc_i  input  PC_WIDTH  corrected PC.
REQ-007 SHALL have imem_req_o  output  1  single-cycle fetch request pulse.
REQ-008 SHALL have imem_addr_o  output  PC_WIDTH  fetch address, valid when imem_req_o=1.
REQ-009 SHALL have imem_rvalid_i  input  1  response strobe, at least 1 cycle after request.
REQ-010 SHALL have imem_rdata_i  input  32  instruction word.
REQ-011 SHALL have f_opcode_o 7, f_rd_o/f_rs1_o/f_rs2_o REG_WIDTH, f_func3_o 3, f_func7_o 7, f_imm_o 12, f_pc_o PC_WIDTH, f_valC_o CPU_WIDTH, f_delayPC_o PC_WIDTH  outputs  decoded fields for the decode pipe register.
REQ-012 SHALL have f_bubble_o  output  1  high when no valid instruction presented; drives decode-register bubble.

Function
REQ-013 SHALL implement FSM IDLE, WAIT, FULL, DROP; one outstanding request maximum.
REQ-014 IDLE: imem_req_o=1, imem_addr_o=pc; next state WAIT.
REQ-015 WAIT: on imem_rvalid_i capture rdata into inst_buf, pc into buf_pc; next FULL; else stay.
REQ-016 FULL: f_bubble_o=0; outputs decoded combinationally from inst_buf/buf_pc.
REQ-017 FULL with F_stall_i=0: pc<=pred_pc, imem_req_o=1 with imem_addr_o=pred_pc in same cycle, next WAIT (peak 1 instruction per 2 cycles at latency 1).
REQ-018 FULL with F_stall_i=1: all state and outputs held.
REQ-019 f_bubble_o=1 in IDLE, WAIT, DROP; field outputs then equal reset values.
REQ-020 Decode: opcode=[6:0], rd=[11:7], func3=[14:12], rs1=[19:15], rs2=[24:20], func7=[31:25], imm=[31:20].
REQ-021 rs1=`RNONE for LUI/AUIPC/JAL; rs2=`RNONE unless R, S or B type; rd=`RNONE for S and B type.
REQ-022 f_valC_o = format immediate (I,S,B,U,J) sign-extended to CPU_WIDTH; 0 for R type.
REQ-023 f_delayPC_o = buf_pc+4, modulo 2^PC_WIDTH.
REQ-024 pred_pc: JAL -> buf_pc+J-imm; B type with negative imm -> buf_pc+B-imm; all else incl. JALR -> buf_pc+4; wrap modulo 2^PC_WIDTH.
REQ-025 redirect_i has priority over F_stall_i and all transitions; pc<=redirect_pc_i with bits[1:0] cleared; buffer invalidated.
REQ-026 Redirect next state: FULL->IDLE; WAIT with rvalid same cycle->IDLE (response discarded); WAIT without rvalid->DROP; IDLE->DROP (stale request already issued).
REQ-027 DROP: no request; on imem_rvalid_i discard data, next IDLE; redirect in DROP updates pc only.
REQ-028 imem_rvalid_i in IDLE or FULL SHALL be ignored.

Reset
REQ-029 rst_i=1 at edge: state IDLE, pc=RESET_PC, inst_buf=0, imem_req_o=0 that cycle, f_bubble_o=1, f_rd/rs1/rs2=`RNONE, other field outputs 0; overrides redirect; mid-operation reset abandons outstanding request.

Structure
REQ-030 Opcode constants, FSM encoding, PC_WIDTH/CPU_WIDTH/REG_WIDTH/RNONE SHALL live in shared define file.
REQ-031 SHALL instantiate one combinational sub-module imm_gen (instruction in, valC and pred-offset out).

Verification
REQ-032 Reset, RESET_PC='h8000_0000, latency 1: req at addr 'h8000_0000 cycle 1 after reset release, f_bubble_o=0 cycle 3.
REQ-033 ADDI x1,x2,5 (0x00510093) unstalled -> rd=1, rs1=2, rs2=`RNONE, valC=5, delayPC=pc+4, next req addr pc+4.
REQ-034 JAL offset -8 at pc 'h100 -> next addr 'hF8; BEQ +16 at 'h200 -> next addr 'h204.
REQ-035 F_stall_i high 3 cycles in FULL -> outputs stable, no imem_req_o; release -> request next cycle.
REQ-036 redirect_i to 'h400 in WAIT, rvalid 2 cycles later -> data dropped, f_bubble_o stays 1, next req addr 'h400.
REQ-037 redirect_i and F_stall_i together in FULL -> IDLE, then req addr redirect_pc_i.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, opcode constants and fetch FSM encoding.
package fetch_stage_pkg;
  localparam int PC_WIDTH = 32;
  localparam int CPU_WIDTH = 32;
  localparam int REG_WIDTH = 6;
  localparam logic [REG_WIDTH-1:0] RNONE = 6'h20;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FULL, S_DROP} state_t;
endpackage

// File: rtl/fetch_stage_imm_gen.sv
// fetch_stage_imm_gen: format immediate and static next-PC offset for one instruction.
module fetch_stage_imm_gen
  import fetch_stage_pkg::*;
(
  input  logic [31:0]          inst,
  output logic [CPU_WIDTH-1:0] val_c,
  output logic [PC_WIDTH-1:0]  pred_off
);
  logic [6:0] op;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, imm;
  assign op = inst[6:0];
  assign i_imm = {{20{inst[31]}}, inst[31:20]};
  assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign u_imm = {inst[31:12], 12'b0};
  assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm = (op == OP_STORE) ? s_imm :
               (op == OP_BRANCH) ? b_imm :
               (op == OP_LUI || op == OP_AUIPC) ? u_imm :
               (op == OP_JAL) ? j_imm : i_imm;
  assign val_c = (op == OP_REG) ? '0 : CPU_WIDTH'($signed(imm));
  // backward branches predicted taken, forward ones not taken
  assign pred_off = (op == OP_JAL || (op == OP_BRANCH && inst[31])) ? PC_WIDTH'($signed(imm)) : PC_WIDTH'(4);
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with static prediction and redirect handling.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 'h8000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 F_stall_i,
  input  logic                 redirect_i,
  input  logic [PC_WIDTH-1:0]  redirect_pc_i,
  output logic                 imem_req_o,
  output logic [PC_WIDTH-1:0]  imem_addr_o,
  input  logic                 imem_rvalid_i,
  input  logic [31:0]          imem_rdata_i,
  output logic [6:0]           f_opcode_o,
  output logic [REG_WIDTH-1:0] f_rd_o,
  output logic [REG_WIDTH-1:0] f_rs1_o,
  output logic [REG_WIDTH-1:0] f_rs2_o,
  output logic [2:0]           f_func3_o,
  output logic [6:0]           f_func7_o,
  output logic [11:0]          f_imm_o,
  output logic [PC_WIDTH-1:0]  f_pc_o,
  output logic [CPU_WIDTH-1:0] f_valC_o,
  output logic [PC_WIDTH-1:0]  f_delayPC_o,
  output logic                 f_bubble_o
);
  state_t state;
  logic [PC_WIDTH-1:0] pc, buf_pc, pred_pc, pred_off;
  logic [31:0] inst_buf;
  logic [CPU_WIDTH-1:0] val_c;
  logic [6:0] op;
  logic full;
  fetch_stage_imm_gen imm_gen (.inst(inst_buf), .val_c(val_c), .pred_off(pred_off));
  assign full = state == S_FULL;
  assign op = inst_buf[6:0];
  assign pred_pc = buf_pc + pred_off;
  assign imem_req_o = !rst_i && (state == S_IDLE || (full && !F_stall_i && !redirect_i));
  assign imem_addr_o = full ? pred_pc : pc;
  assign f_bubble_o = !full;
  assign f_opcode_o = full ? op : '0;
  assign f_rd_o = (full && op != OP_STORE && op != OP_BRANCH) ? REG_WIDTH'(inst_buf[11:7]) : RNONE;
  assign f_rs1_o = (full && op != OP_LUI && op != OP_AUIPC && op != OP_JAL) ? REG_WIDTH'(inst_buf[19:15]) : RNONE;
  assign f_rs2_o = (full && (op == OP_REG || op == OP_STORE || op == OP_BRANCH)) ? REG_WIDTH'(inst_buf[24:20]) : RNONE;
  assign f_func3_o = full ? inst_buf[14:12] : '0;
  assign f_func7_o = full ? inst_buf[31:25] : '0;
  assign f_imm_o = full ? inst_buf[31:20] : '0;
  assign f_pc_o = full ? buf_pc : '0;
  assign f_valC_o = full ? val_c : '0;
  assign f_delayPC_o = full ? buf_pc + PC_WIDTH'(4) : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      inst_buf <= '0;
      buf_pc <= '0;
    end else if (redirect_i) begin
      pc <= redirect_pc_i & ~PC_WIDTH'(3);
      // an in-flight request must drain before a fresh fetch may issue
      state <= (state == S_IDLE || ((state == S_WAIT || state == S_DROP) && !imem_rvalid_i)) ? S_DROP : S_IDLE;
    end else begin
      case (state)
        S_IDLE: state <= S_WAIT;
        S_WAIT: if (imem_rvalid_i) begin
          inst_buf <= imem_rdata_i;
          buf_pc <= pc;
          state <= S_FULL;
        end
        S_FULL: if (!F_stall_i) begin
          pc <= pred_pc;
          state <= S_WAIT;
        end
        default: if (imem_rvalid_i) state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch timing, decode, prediction, stall, redirect and reset.
module tb_fetch_stage;
  import fetch_stage_pkg::*;
  localparam logic [31:0] ADDI = 32'h0051_0093;
  localparam logic [31:0] JAL_M8 = 32'hFF9F_F06F;
  localparam logic [31:0] BEQ_P16 = 32'h0020_8863;
  localparam logic [31:0] BEQ_M4 = 32'hFE00_0EE3;
  localparam logic [31:0] SW_M4 = 32'hFE51_2E23;
  localparam logic [31:0] LUI = 32'h1234_51B7;
  logic clk = 0, rst, stall, redirect, rvalid, req, bubble;
  logic [31:0] redirect_pc, addr, rdata, f_pc, valc, dpc;
  logic [6:0] opcode, func7;
  logic [5:0] rd, rs1, rs2;
  logic [2:0] func3;
  logic [11:0] imm;
  int checks = 0, failures = 0;
  fetch_stage dut (
    .clk_i(clk), .rst_i(rst), .F_stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .f_opcode_o(opcode), .f_rd_o(rd), .f_rs1_o(rs1), .f_rs2_o(rs2), .f_func3_o(func3),
    .f_func7_o(func7), .f_imm_o(imm), .f_pc_o(f_pc), .f_valC_o(valc), .f_delayPC_o(dpc),
    .f_bubble_o(bubble)
  );
  always #5 clk = ~clk;
  task chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task cyc();
    @(posedge clk);
    #1;
  endtask
  task wait_resp(input logic [31:0] inst);
    rvalid = 1;
    rdata = inst;
    cyc();
    rvalid = 0;
    #2;
  endtask
  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0; rvalid = 0; rdata = 0;
    cyc();
    redirect = 1; redirect_pc = 32'h400;
    #2;
    chk("rst_req", req, 0);
    chk("rst_bubble", bubble, 1);
    chk("rst_rd", rd, RNONE);
    chk("rst_rs1", rs1, RNONE);
    chk("rst_rs2", rs2, RNONE);
    chk("rst_valc", valc, 0);
    chk("rst_pc", f_pc, 0);
    cyc();
    rst = 0; redirect = 0;
    #2;
    chk("boot_req", req, 1);
    chk("boot_addr", addr, 32'h8000_0000);
    chk("boot_bubble", bubble, 1);
    cyc();
    rvalid = 1; rdata = ADDI;
    #2;
    chk("wait_req", req, 0);
    chk("wait_bubble", bubble, 1);
    cyc();
    rvalid = 0;
    #2;
    chk("addi_bubble", bubble, 0);
    chk("addi_op", opcode, 7'h13);
    chk("addi_rd", rd, 1);
    chk("addi_rs1", rs1, 2);
    chk("addi_rs2", rs2, RNONE);
    chk("addi_f3", func3, 0);
    chk("addi_f7", func7, 0);
    chk("addi_imm", imm, 5);
    chk("addi_valc", valc, 5);
    chk("addi_pc", f_pc, 32'h8000_0000);
    chk("addi_dpc", dpc, 32'h8000_0004);
    chk("addi_req", req, 1);
    chk("addi_next", addr, 32'h8000_0004);
    stall = 1;
    #1;
    chk("stall_req0", req, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #2;
      chk("stall_req", req, 0);
      chk("stall_bubble", bubble, 0);
      chk("stall_rd", rd, 1);
      chk("stall_pc", f_pc, 32'h8000_0000);
    end
    stall = 0;
    #1;
    chk("unstall_req", req, 1);
    chk("unstall_addr", addr, 32'h8000_0004);
    cyc();
    redirect = 1; redirect_pc = 32'h400;
    #2;
    chk("rw_req", req, 0);
    cyc();
    redirect = 0;
    #2;
    chk("drop_req", req, 0);
    chk("drop_bubble", bubble, 1);
    cyc();
    rvalid = 1; rdata = ADDI;
    #2;
    chk("drop2_req", req, 0);
    chk("drop2_bubble", bubble, 1);
    cyc();
    rvalid = 0;
    #2;
    chk("dropx_bubble", bubble, 1);
    chk("dropx_req", req, 1);
    chk("dropx_addr", addr, 32'h400);
    cyc();
    wait_resp(ADDI);
    chk("p400_pc", f_pc, 32'h400);
    redirect = 1; stall = 1; redirect_pc = 32'h103;
    #2;
    chk("rs_req", req, 0);
    cyc();
    redirect = 0; stall = 0;
    #2;
    chk("rs_bubble", bubble, 1);
    chk("rs_req2", req, 1);
    chk("rs_addr", addr, 32'h100);
    cyc();
    wait_resp(JAL_M8);
    chk("jal_valc", valc, 32'hFFFF_FFF8);
    chk("jal_rd", rd, 0);
    chk("jal_rs1", rs1, RNONE);
    chk("jal_rs2", rs2, RNONE);
    chk("jal_next", addr, 32'hF8);
    cyc();
    rvalid = 1; rdata = JAL_M8; redirect = 1; redirect_pc = 32'h200;
    cyc();
    rvalid = 0; redirect = 0;
    #2;
    chk("wr_bubble", bubble, 1);
    chk("wr_req", req, 1);
    chk("wr_addr", addr, 32'h200);
    cyc();
    wait_resp(BEQ_P16);
    chk("beq_rd", rd, RNONE);
    chk("beq_rs1", rs1, 1);
    chk("beq_rs2", rs2, 2);
    chk("beq_valc", valc, 16);
    chk("beq_next", addr, 32'h204);
    stall = 1; rvalid = 1; rdata = JAL_M8;
    cyc();
    rvalid = 0;
    #2;
    chk("stray_valc", valc, 16);
    chk("stray_rd", rd, RNONE);
    chk("stray_bubble", bubble, 0);
    stall = 0; redirect = 1; redirect_pc = 32'h300;
    cyc();
    redirect = 0;
    cyc();
    wait_resp(BEQ_M4);
    chk("bneg_valc", valc, 32'hFFFF_FFFC);
    chk("bneg_next", addr, 32'h2FC);
    redirect = 1; redirect_pc = 32'hFFFF_FFFE;
    cyc();
    redirect = 0;
    #2;
    chk("wrap_addr", addr, 32'hFFFF_FFFC);
    cyc();
    wait_resp(ADDI);
    chk("wrap_pc", f_pc, 32'hFFFF_FFFC);
    chk("wrap_dpc", dpc, 0);
    chk("wrap_next", addr, 0);
    cyc();
    rst = 1; redirect = 1; redirect_pc = 32'h500;
    #2;
    chk("mrst_req", req, 0);
    cyc();
    rst = 0; redirect = 0; rvalid = 1; rdata = ADDI;
    #2;
    chk("mrst_bubble", bubble, 1);
    chk("mrst_req2", req, 1);
    chk("mrst_addr", addr, 32'h8000_0000);
    cyc();
    wait_resp(SW_M4);
    chk("sw_valc", valc, 32'hFFFF_FFFC);
    chk("sw_rd", rd, RNONE);
    chk("sw_rs1", rs1, 2);
    chk("sw_rs2", rs2, 5);
    chk("sw_f3", func3, 2);
    chk("sw_next", addr, 32'h8000_0004);
    cyc();
    wait_resp(LUI);
    chk("lui_valc", valc, 32'h1234_5000);
    chk("lui_rd", rd, 3);
    chk("lui_rs1", rs1, RNONE);
    chk("lui_rs2", rs2, RNONE);
    chk("lui_pc", f_pc, 32'h8000_0004);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
